pick_motion: RTL and testbench
==============================

PICK_MOTION -- requirements
Module: pick_motion

Interface
REQ-001 Parameter Y_MIN, default 32, lowest legal pickY (top pin row).
REQ-002 Parameter Y_MAX, default 479, highest legal pickY (bottom pin row).
REQ-003 Parameter HOLD_FRAMES, default 16, consecutive frame ticks of Space needed to set tension.
REQ-004 Parameter ACCEL_FRAMES, default 8, frame ticks of continuous movement before fast step applies.
REQ-005 Clk  input  1  system clock; all state on posedge Clk.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 frame_clk  input  1  VGA vsync level, asynchronous to Clk.
REQ-008 keycode  input  8  current USB HID keycode; 0x1A = W (up), 0x16 = S (down), 0x2C = Space (tension), any other value = no key.
REQ-009 enable  input  1  level active; low freezes the block.
REQ-010 pickY  output  10  pick vertical position in pixels; feeds the level-check stage.
REQ-011 openner  output  1  high = no tension applied; low = tension set, level may complete.
REQ-012 moving  output  1  high for exactly one Clk cycle on each tick where pickY changes.

Function
REQ-013 frame_clk SHALL pass through a 2-flop synchronizer; a one-Clk tick pulse SHALL be generated on its synchronized rising edge, giving 2-3 Clk latency from the input edge.
REQ-014 All motion and FSM updates SHALL occur only on tick cycles with enable = 1; on all other cycles state holds.
REQ-015 The FSM SHALL have three states: IDLE, TENSION and SET.
REQ-016 IDLE: openner = 1; a tick with W moves up, a tick with S moves down, and a tick with Space goes to TENSION with hold_cnt = 1.
REQ-017 TENSION: openner = 1; pickY frozen; a tick with Space increments hold_cnt, and when hold_cnt reaches HOLD_FRAMES the FSM goes to SET; a tick without Space returns to IDLE with hold_cnt = 0.
REQ-018 SET: openner = 0; pickY frozen; a tick without Space returns to IDLE, where openner = 1 from the next cycle.
REQ-019 openner SHALL be registered and change on the Clk edge that changes state.
REQ-020 Step size SHALL be 1 px while accel_cnt < ACCEL_FRAMES and 4 px after; accel_cnt (saturating, 4 bits) increments on each moving tick.
REQ-021 accel_cnt SHALL clear on any tick where neither W nor S is held, or on a direction change.
REQ-022 Position arithmetic SHALL use 11 bits signed and clamp the result to [Y_MIN, Y_MAX]; no wrap-around.
REQ-023 A step that is blocked at a bound SHALL leave pickY unchanged and SHALL NOT pulse moving.
REQ-024 Only one keycode is present per cycle, so Space is never simultaneous with W or S; a keycode change between ticks SHALL have no effect until the next tick.
REQ-025 When enable goes low, the FSM SHALL be forced to IDLE (openner = 1) on the next Clk, hold_cnt and accel_cnt SHALL clear, and pickY SHALL be retained.

Reset
REQ-026 Reset SHALL set the following immediately: pickY = Y_MIN, openner = 1, moving = 0, state IDLE, hold_cnt = 0, accel_cnt = 0, and synchronizer flops = 0.
REQ-027 Reset asserted mid-TENSION or mid-SET SHALL abort to the reset values, and no tick SHALL be generated on the first cycle after release.

Verification
REQ-028 Reset, then enable = 1 and keycode 0x16 for 3 ticks -> pickY 32→33→34→35, with moving pulsing on each tick.
REQ-029 Hold 0x16 for 20 ticks from pickY = 32 -> pickY = 32+8×1+12×4 = 88 after tick 20.
REQ-030 pickY = 478, keycode 0x16 with accel_cnt saturated -> pickY = 479 (clamped); the next tick leaves pickY at 479 with no moving pulse.
REQ-031 Keycode 0x2C for 15 ticks -> openner stays 1; on tick 16 -> openner = 0; then keycode 0x00 for 1 tick -> openner = 1 and pickY unchanged throughout.
REQ-032 Reach SET, then drop enable -> openner = 1 on the next Clk; reassert enable with 0x2C -> 16 more ticks are needed before openner = 0.
REQ-033 Assert Reset asynchronously in TENSION at hold_cnt = 10 -> openner = 1 and pickY = 32 before the next Clk edge; after release, 16 fresh Space ticks are needed.

Source files
------------

// File: rtl/pick_motion_if.sv
// Bus bundle between the input/video side and pick_motion.
// master drives keys, enable and vsync; slave returns pick position and tension status.
interface pick_motion_if;
    logic       frame_clk;
    logic [7:0] keycode;
    logic       enable;
    logic [9:0] pickY;
    logic       openner;
    logic       moving;

    modport master (
        output frame_clk, keycode, enable,
        input  pickY, openner, moving
    );

    modport slave (
        input  frame_clk, keycode, enable,
        output pickY, openner, moving
    );
endinterface

// File: rtl/pick_motion.sv
// Lock-pick vertical motion and tension control, advanced once per synchronized frame tick.
// State table:
//   IDLE    | pick free to move with W/S; no tension (openner = 1)
//   TENSION | Space being held, counting frames; pick frozen (openner = 1)
//   SET     | tension applied; pick frozen (openner = 0)
module pick_motion #(
    parameter int Y_MIN        = 32,
    parameter int Y_MAX        = 479,
    parameter int HOLD_FRAMES  = 16,
    parameter int ACCEL_FRAMES = 8
) (
    input logic          Clk,
    input logic          Reset,
    pick_motion_if.slave bus
);
    typedef enum logic [1:0] {IDLE, TENSION, SET} state_t;

    localparam int                 HW     = $clog2(HOLD_FRAMES + 1);
    localparam logic signed [10:0] YMIN_S = 11'(Y_MIN);
    localparam logic signed [10:0] YMAX_S = 11'(Y_MAX);

    state_t           state;
    logic [9:0]       pos_y;
    logic             open_r;
    logic             move_r;
    logic [HW-1:0]    hold_cnt;
    logic [3:0]       accel_cnt;
    logic             last_up;
    logic             fs1, fs2, fs3;
    logic             tick;

    logic             key_up, key_dn, key_sp;
    logic [3:0]       accel_eff;
    logic [3:0]       accel_inc;
    logic signed [10:0] step;
    logic signed [10:0] pos_cur;
    logic signed [10:0] pos_sum;
    logic signed [10:0] pos_clamp;
    logic [9:0]       pos_next;
    logic [HW-1:0]    hold_inc;

    // fs3 is the previous synchronized level, so tick marks a rising edge only
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fs1 <= 1'b0;
            fs2 <= 1'b0;
            fs3 <= 1'b0;
        end else begin
            fs1 <= bus.frame_clk;
            fs2 <= fs1;
            fs3 <= fs2;
        end
    end

    assign tick = fs2 & ~fs3;

    always_comb begin
        key_up    = (bus.keycode == 8'h1A);
        key_dn    = (bus.keycode == 8'h16);
        key_sp    = (bus.keycode == 8'h2C);
        accel_eff = (key_up != last_up) ? 4'd0 : accel_cnt;
        accel_inc = (accel_eff == 4'hF) ? 4'hF : accel_eff + 4'd1;
        step      = (int'(accel_eff) < ACCEL_FRAMES) ? 11'sd1 : 11'sd4;
        pos_cur   = signed'({1'b0, pos_y});
        pos_sum   = key_up ? (pos_cur - step) : (pos_cur + step);
        if (pos_sum < YMIN_S)
            pos_clamp = YMIN_S;
        else if (pos_sum > YMAX_S)
            pos_clamp = YMAX_S;
        else
            pos_clamp = pos_sum;
        pos_next  = 10'(pos_clamp);
        hold_inc  = hold_cnt + HW'(1);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            pos_y     <= 10'(Y_MIN);
            open_r    <= 1'b1;
            move_r    <= 1'b0;
            hold_cnt  <= '0;
            accel_cnt <= 4'd0;
            last_up   <= 1'b0;
        end else begin
            move_r <= 1'b0;
            if (!bus.enable) begin
                state     <= IDLE;
                open_r    <= 1'b1;
                hold_cnt  <= '0;
                accel_cnt <= 4'd0;
            end else if (tick) begin
                unique case (state)
                    IDLE: begin
                        if (key_sp) begin
                            accel_cnt <= 4'd0;
                            if (HOLD_FRAMES <= 1) begin
                                state    <= SET;
                                open_r   <= 1'b0;
                                hold_cnt <= HW'(HOLD_FRAMES);
                            end else begin
                                state    <= TENSION;
                                hold_cnt <= HW'(1);
                            end
                        end else if (key_up || key_dn) begin
                            last_up <= key_up;
                            // a step clamped back onto the current row is not a move
                            if (pos_next != pos_y) begin
                                pos_y     <= pos_next;
                                move_r    <= 1'b1;
                                accel_cnt <= accel_inc;
                            end else begin
                                accel_cnt <= accel_eff;
                            end
                        end else begin
                            accel_cnt <= 4'd0;
                        end
                    end
                    TENSION: begin
                        if (key_sp) begin
                            hold_cnt <= hold_inc;
                            if (hold_inc == HW'(HOLD_FRAMES)) begin
                                state  <= SET;
                                open_r <= 1'b0;
                            end
                        end else begin
                            state    <= IDLE;
                            hold_cnt <= '0;
                        end
                    end
                    SET: begin
                        if (!key_sp) begin
                            state    <= IDLE;
                            open_r   <= 1'b1;
                            hold_cnt <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.pickY   = pos_y;
    assign bus.openner = open_r;
    assign bus.moving  = move_r;
endmodule

// File: tb/tb_pick_motion.sv
// Scoreboard bench for pick_motion: a frame-level reference model queues expected moves and
// tension changes; an independent monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_pick_motion;
    localparam int Y_MIN = 32;
    localparam int Y_MAX = 479;
    localparam int HOLD  = 16;
    localparam int ACCEL = 8;
    localparam logic [7:0] K_W  = 8'h1A;
    localparam logic [7:0] K_S  = 8'h16;
    localparam logic [7:0] K_SP = 8'h2C;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    pick_motion_if bus();

    pick_motion #(.Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .HOLD_FRAMES(HOLD), .ACCEL_FRAMES(ACCEL))
        dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    // expected-output queues
    int pos_q[$];
    bit open_q[$];

    // reference model: pick row, consecutive Space frames, consecutive same-direction moves
    int m_pos, m_run, m_streak, m_dir;
    bit m_open;

    // monitor trackers
    int mon_pos;
    bit mon_open;
    bit prev_moving;
    int move_cnt;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_tick(input logic [7:0] key);
        int dir, step, np;
        bit new_open;
        if (key == K_SP) begin
            m_run++;
            m_streak = 0;
        end else if (m_run > 0) begin
            m_run = 0;
        end else if (key == K_W || key == K_S) begin
            dir = (key == K_W) ? -1 : 1;
            if (dir != m_dir) m_streak = 0;
            m_dir = dir;
            step = (m_streak < ACCEL) ? 1 : 4;
            np = m_pos + dir * step;
            if (np < Y_MIN) np = Y_MIN;
            if (np > Y_MAX) np = Y_MAX;
            if (np != m_pos) begin
                m_pos = np;
                pos_q.push_back(np);
                if (m_streak < 15) m_streak++;
            end
        end else begin
            m_streak = 0;
        end
        new_open = (m_run < HOLD);
        if (new_open != m_open) begin
            open_q.push_back(new_open);
            m_open = new_open;
        end
    endtask

    task automatic model_drop();
        m_run = 0;
        m_streak = 0;
        if (!m_open) begin
            open_q.push_back(1'b1);
            m_open = 1'b1;
        end
    endtask

    // one vsync pulse carrying key; keycode is scrambled between frames
    task automatic frame(input logic [7:0] key);
        @(posedge Clk);
        #1 bus.keycode = key;
        #($urandom_range(1, 8));
        bus.frame_clk = 1'b1;
        if (bus.enable) model_tick(key);
        repeat (5) @(posedge Clk);
        #1 bus.frame_clk = 1'b0;
        bus.keycode = 8'($urandom);
        repeat (3) @(posedge Clk);
    endtask

    task automatic frames(input logic [7:0] key, input int n);
        for (int i = 0; i < n; i++) frame(key);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        bus.frame_clk = 1'b0;
        pos_q.delete();
        open_q.delete();
        m_pos = Y_MIN; m_run = 0; m_streak = 0; m_dir = 0; m_open = 1'b1;
        mon_pos = Y_MIN; mon_open = 1'b1; prev_moving = 1'b0; move_cnt = 0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        check({tag, "_pending_moves"}, pos_q.size(), 0);
        check({tag, "_pending_open"}, open_q.size(), 0);
        check({tag, "_model_pos"}, int'(bus.pickY), m_pos);
    endtask

    always @(negedge Clk) begin
        int e;
        if (!Reset) begin
            if (bus.moving) begin
                move_cnt++;
                if (prev_moving) check("moving_width", 2, 1);
                if (pos_q.size() == 0) begin
                    check("unexpected_move", int'(bus.pickY), mon_pos);
                end else begin
                    e = pos_q.pop_front();
                    check("move_pos", int'(bus.pickY), e);
                end
                mon_pos = int'(bus.pickY);
            end else if (int'(bus.pickY) != mon_pos) begin
                check("silent_pos_change", int'(bus.pickY), mon_pos);
                mon_pos = int'(bus.pickY);
            end
            if (bus.openner != mon_open) begin
                if (open_q.size() == 0) begin
                    check("unexpected_openner", int'(bus.openner), int'(mon_open));
                end else begin
                    e = int'(open_q.pop_front());
                    check("openner_change", int'(bus.openner), e);
                end
                mon_open = bus.openner;
            end
            prev_moving = bus.moving;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mc;
        bus.frame_clk = 1'b0;
        bus.keycode = 8'h00;
        bus.enable = 1'b1;
        do_reset();

        check("reset_pickY", int'(bus.pickY), Y_MIN);
        check("reset_openner", int'(bus.openner), 1);
        check("reset_moving", int'(bus.moving), 0);

        // three down steps of 1 px
        frames(K_S, 3);
        check("down3_pickY", int'(bus.pickY), 35);
        check("down3_moves", move_cnt, 3);
        drain_check("down3");

        // acceleration: 8 steps of 1 then 12 of 4
        do_reset();
        frames(K_S, 20);
        check("accel20_pickY", int'(bus.pickY), 88);
        drain_check("accel20");

        // bottom clamp with saturated acceleration
        do_reset();
        frames(K_S, 2);
        frame(8'h00);
        frames(K_S, 117);
        check("pre_clamp_pickY", int'(bus.pickY), 478);
        frame(K_S);
        check("clamp_pickY", int'(bus.pickY), Y_MAX);
        mc = move_cnt;
        frame(K_S);
        check("blocked_pickY", int'(bus.pickY), Y_MAX);
        check("blocked_no_move", move_cnt, mc);
        drain_check("clamp");

        // tension hold and release
        do_reset();
        frames(K_SP, 15);
        check("tension15_openner", int'(bus.openner), 1);
        frame(K_SP);
        check("tension16_openner", int'(bus.openner), 0);
        frame(8'h00);
        check("release_openner", int'(bus.openner), 1);
        check("release_pickY", int'(bus.pickY), Y_MIN);
        drain_check("tension");

        // enable drop out of SET, then a fresh hold is needed
        do_reset();
        frames(K_SP, 16);
        check("set_openner", int'(bus.openner), 0);
        @(posedge Clk);
        #1 bus.enable = 1'b0;
        model_drop();
        @(posedge Clk);
        #1 check("disable_openner", int'(bus.openner), 1);
        @(posedge Clk);
        #1 bus.enable = 1'b1;
        frames(K_SP, 15);
        check("rehold15_openner", int'(bus.openner), 1);
        frame(K_SP);
        check("rehold16_openner", int'(bus.openner), 0);
        drain_check("disable");

        // asynchronous reset in the middle of a hold
        do_reset();
        frames(K_S, 5);
        frames(K_SP, 10);
        drain_check("pre_async");
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1 check("async_pickY", int'(bus.pickY), Y_MIN);
        check("async_openner", int'(bus.openner), 1);
        do_reset();
        frames(K_SP, 15);
        check("post_reset15_openner", int'(bus.openner), 1);
        frame(K_SP);
        check("post_reset16_openner", int'(bus.openner), 0);
        drain_check("async");

        // randomized bursts with occasional disabled frames
        do_reset();
        for (int b = 0; b < 40; b++) begin
            int r, n;
            logic [7:0] k;
            r = int'($urandom_range(0, 9));
            n = int'($urandom_range(1, 20));
            if (r < 3) k = K_S;
            else if (r < 6) k = K_W;
            else if (r < 8) k = K_SP;
            else if (r == 8) k = 8'h00;
            else k = 8'($urandom);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 19) == 0) begin
                    @(posedge Clk);
                    #1 bus.enable = 1'b0;
                    model_drop();
                    frame(k);
                    #1 bus.enable = 1'b1;
                end else begin
                    frame(k);
                end
            end
        end
        repeat (4) @(posedge Clk);
        #1 drain_check("random");
        check("random_openner", int'(bus.openner), int'(m_open));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
